// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared processor constants for the register-file write arbiter: index/data widths,
// requester count and requester IDs, plus the round-robin pointer helper.
package regfile_wr_arbiter_pkg;

  localparam int REG_W   = 6;
  localparam int DATA_W  = 16;
  localparam int NUM_REQ = 3;
  localparam int NUM_RD  = 3;
  localparam int NREGS   = 1 << REG_W;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_MDU = 2'd2
  } req_id_e;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  // Requester index reached by stepping `step` places past `base`, modulo NUM_REQ.
  function automatic logic [1:0] rr_offset(input logic [1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side write handshake bundle: one valid/ready pair plus payload per requester;
// the carry fields belong to requester 0 (ALU) only.
interface regfile_wr_arbiter_if;

  logic [regfile_wr_arbiter_pkg::NUM_REQ-1:0]                                    req_valid;
  logic [regfile_wr_arbiter_pkg::NUM_REQ-1:0]                                    req_ready;
  logic [regfile_wr_arbiter_pkg::NUM_REQ-1:0][regfile_wr_arbiter_pkg::REG_W-1:0]  req_reg;
  logic [regfile_wr_arbiter_pkg::NUM_REQ-1:0][regfile_wr_arbiter_pkg::DATA_W-1:0] req_data;
  logic                                                                          req_carry;
  logic                                                                          req_carry_en;

  modport master (
    output req_valid, req_reg, req_data, req_carry, req_carry_en,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_reg, req_data, req_carry, req_carry_en,
    output req_ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// 64-entry pending-write scoreboard: decode sets a bit when it claims a destination,
// a committed register-file write clears it; a set on the same edge wins.
module regfile_scoreboard
  import regfile_wr_arbiter_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  reg_idx_t                      issue_reg,
  output logic                          issue_ready,
  input  logic [NUM_RD-1:0][REG_W-1:0]  rd_reg,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic                          wr1_enable,
  input  reg_idx_t                      wr1,
  input  logic                          wr2_enable,
  input  reg_idx_t                      wr2
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_ready) set_mask[issue_reg] = 1'b1;
    if (wr1_enable)                 clr_mask[wr1]       = 1'b1;
    if (wr2_enable)                 clr_mask[wr2]       = 1'b1;
  end

  // NOTE: this is a 64-bit flop vector, not a RAM, so resetting every bit is cheap and required.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~clr_mask) | set_mask;
  end

  assign issue_ready = !busy[issue_reg];

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) rd_busy[k] = busy[rd_reg[k]];
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-port round-robin register-file write arbiter for ALU/LSU/MDU with registered write
// outputs. Define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = NUM_REQ
) (
  input  logic                          clock,
  input  logic                          reset,
  regfile_wr_arbiter_if.slave           req,
  input  logic                          issue_valid,
  input  reg_idx_t                      issue_reg,
  output logic                          issue_ready,
  input  logic [NUM_RD-1:0][REG_W-1:0]  rd_reg,
  output logic [NUM_RD-1:0]             rd_busy,
  output reg_idx_t                      reg_wr1,
  output reg_idx_t                      reg_wr2,
  output data_t                         reg_wr1_data,
  output data_t                         reg_wr2_data,
  output logic                          reg_wr1_enable,
  output logic                          reg_wr2_enable,
  output logic                          carrybit_wr,
  output logic                          carrybit_wr_enable
);

  logic [1:0]      rr_ptr;
  logic [NREQ-1:0] grant;
  logic            p1_hit, p2_hit;
  logic [1:0]      p1_idx, p2_idx, idx;

  // Scan from rr_ptr; port 2 skips any candidate aiming at port 1's register.
  always_comb begin
    grant  = '0;
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    p1_idx = '0;
    p2_idx = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_offset(rr_ptr, k);
      if (req.req_valid[idx] && !reset) begin
        if (!p1_hit) begin
          p1_hit      = 1'b1;
          p1_idx      = idx;
          grant[idx]  = 1'b1;
        end else if (!p2_hit && (req.req_reg[idx] != req.req_reg[p1_idx])) begin
          p2_hit      = 1'b1;
          p2_idx      = idx;
          grant[idx]  = 1'b1;
        end
      end
    end
  end

  assign req.req_ready = grant;

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr             <= '0;
      reg_wr1            <= '0;
      reg_wr2            <= '0;
      reg_wr1_data       <= '0;
      reg_wr2_data       <= '0;
      reg_wr1_enable     <= 1'b0;
      reg_wr2_enable     <= 1'b0;
      carrybit_wr        <= 1'b0;
      carrybit_wr_enable <= 1'b0;
    end else begin
      reg_wr1_enable <= p1_hit;
      reg_wr2_enable <= p2_hit;
      if (p1_hit) begin
        reg_wr1      <= req.req_reg[p1_idx];
        reg_wr1_data <= req.req_data[p1_idx];
      end
      if (p2_hit) begin
        reg_wr2      <= req.req_reg[p2_idx];
        reg_wr2_data <= req.req_data[p2_idx];
      end
      if (p2_hit)      rr_ptr <= rr_offset(p2_idx, 1);
      else if (p1_hit) rr_ptr <= rr_offset(p1_idx, 1);
      carrybit_wr_enable <= grant[REQ_ALU] && req.req_carry_en;
      if (grant[REQ_ALU] && req.req_carry_en) carrybit_wr <= req.req_carry;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_ready (issue_ready),
    .rd_reg      (rd_reg),
    .rd_busy     (rd_busy),
    .wr1_enable  (reg_wr1_enable),
    .wr1         (reg_wr1),
    .wr2_enable  (reg_wr2_enable),
    .wr2         (reg_wr2)
  );
`else
  // Without the scoreboard decode is never stalled and no read is ever flagged.
  assign issue_ready = 1'b1;
  assign rd_busy     = '0;
  logic unused_issue_inputs;
  assign unused_issue_inputs = ^{issue_valid, issue_reg, rd_reg};
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a queue-based arbitration model checked every
// negedge, plus literal expectations for the key cases (scoreboard cases when enabled).
module tb_regfile_wr_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_wr_arbiter_if rif ();

  logic             issue_valid;
  logic [5:0]       issue_reg;
  logic             issue_ready;
  logic [2:0][5:0]  rd_reg;
  logic [2:0]       rd_busy;
  logic [5:0]       reg_wr1, reg_wr2;
  logic [15:0]      reg_wr1_data, reg_wr2_data;
  logic             reg_wr1_enable, reg_wr2_enable;
  logic             carrybit_wr, carrybit_wr_enable;

  regfile_wr_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .req                (rif),
    .issue_valid        (issue_valid),
    .issue_reg          (issue_reg),
    .issue_ready        (issue_ready),
    .rd_reg             (rd_reg),
    .rd_busy            (rd_busy),
    .reg_wr1            (reg_wr1),
    .reg_wr2            (reg_wr2),
    .reg_wr1_data       (reg_wr1_data),
    .reg_wr2_data       (reg_wr2_data),
    .reg_wr1_enable     (reg_wr1_enable),
    .reg_wr2_enable     (reg_wr2_enable),
    .carrybit_wr        (carrybit_wr),
    .carrybit_wr_enable (carrybit_wr_enable)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list requesters in priority order, hand out up to two grants, skip a same-register clash.
  function automatic void model_grant(input int ptr, input logic [2:0] v, input logic [2:0][5:0] r,
                                      input logic rst, output logic [2:0] g,
                                      output int first, output int second);
    int order[$];
    g = 3'b000; first = -1; second = -1;
    for (int k = 0; k < 3; k++) order.push_back((ptr + k) % 3);
    foreach (order[j]) begin
      int i;
      i = order[j];
      if (v[i] && !rst) begin
        if (first < 0) begin
          first = i; g[i] = 1'b1;
        end else if (second < 0 && r[i] != r[first]) begin
          second = i; g[i] = 1'b1;
        end
      end
    end
  endfunction

  int          m_ptr;
  logic        m_wr1_en, m_wr2_en, m_c_en, m_c;
  logic [5:0]  m_wr1, m_wr2;
  logic [15:0] m_d1, m_d2;
  logic [63:0] m_busy;

  always @(posedge clock or posedge reset) begin
    logic [2:0] g;
    int f, s;
    logic [63:0] nb;
    if (reset) begin
      m_ptr <= 0; m_wr1_en <= 0; m_wr2_en <= 0; m_c_en <= 0; m_c <= 0;
      m_wr1 <= 0; m_wr2 <= 0; m_d1 <= 0; m_d2 <= 0; m_busy <= 0;
    end else begin
      model_grant(m_ptr, rif.req_valid, rif.req_reg, 1'b0, g, f, s);
      m_wr1_en <= (f >= 0);
      m_wr2_en <= (s >= 0);
      if (f >= 0) begin m_wr1 <= rif.req_reg[f]; m_d1 <= rif.req_data[f]; end
      if (s >= 0) begin m_wr2 <= rif.req_reg[s]; m_d2 <= rif.req_data[s]; end
      if (s >= 0)      m_ptr <= (s + 1) % 3;
      else if (f >= 0) m_ptr <= (f + 1) % 3;
      m_c_en <= g[0] && rif.req_carry_en;
      if (g[0] && rif.req_carry_en) m_c <= rif.req_carry;
      nb = m_busy;
      if (m_wr1_en) nb[m_wr1] = 1'b0;
      if (m_wr2_en) nb[m_wr2] = 1'b0;
      if (issue_valid && !m_busy[issue_reg]) nb[issue_reg] = 1'b1;
      m_busy <= nb;
    end
  end

  always @(negedge clock) begin
    logic [2:0] g;
    int f, s;
    model_grant(m_ptr, rif.req_valid, rif.req_reg, reset, g, f, s);
    check("ready", rif.req_ready, g);
    check("wr1_en", reg_wr1_enable, m_wr1_en);
    check("wr2_en", reg_wr2_enable, m_wr2_en);
    check("wr1", {reg_wr1, reg_wr1_data}, {m_wr1, m_d1});
    check("wr2", {reg_wr2, reg_wr2_data}, {m_wr2, m_d2});
    check("carry", {carrybit_wr_enable, carrybit_wr}, {m_c_en, m_c});
`ifdef REGFILE_SCOREBOARD_EN
    check("issue_ready", issue_ready, !m_busy[issue_reg]);
    for (int k = 0; k < 3; k++) check("rd_busy", rd_busy[k], m_busy[rd_reg[k]]);
`else
    check("issue_ready", issue_ready, 1'b1);
    check("rd_busy", rd_busy, 3'b000);
`endif
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [5:0] r0, r1, r2,
                       input logic [15:0] d0, d1, d2);
    rif.req_valid = v;
    rif.req_reg   = {r2, r1, r0};
    rif.req_data  = {d2, d1, d0};
  endtask

  initial begin
    rif.req_valid = 0; rif.req_reg = '0; rif.req_data = '0;
    rif.req_carry = 0; rif.req_carry_en = 0;
    issue_valid = 0; issue_reg = 0; rd_reg = '0;
    #2 reset = 1'b1;
    step(); step();
    check("reset_outputs", {reg_wr1_enable, reg_wr2_enable, reg_wr1, reg_wr2, reg_wr1_data,
                            reg_wr2_data, carrybit_wr, carrybit_wr_enable}, 64'd0);
    reset = 1'b0;

    // Three-way contention from rr_ptr=0.
    drive(3'b111, 6'd5, 6'd6, 6'd7, 16'h1111, 16'h2222, 16'h3333);
    #1 check("c24_ready", rif.req_ready, 3'b011);
    step();
    check("c24_wr1", {reg_wr1_enable, reg_wr1, reg_wr1_data}, {1'b1, 6'd5, 16'h1111});
    check("c24_wr2", {reg_wr2_enable, reg_wr2, reg_wr2_data}, {1'b1, 6'd6, 16'h2222});
    rif.req_valid = 3'b100;
    #1 check("c24_ready2", rif.req_ready, 3'b100);
    step();
    check("c24_wr1b", {reg_wr1_enable, reg_wr1, reg_wr1_data}, {1'b1, 6'd7, 16'h3333});
    check("c24_wr2_hold", {reg_wr2_enable, reg_wr2, reg_wr2_data}, {1'b0, 6'd6, 16'h2222});
    rif.req_valid = 3'b000;
    step();

    // Same-register clash between 0 and 1; rr_ptr back at 0.
    drive(3'b111, 6'd9, 6'd9, 6'd12, 16'haaaa, 16'hbbbb, 16'hcccc);
    #1 check("c25_ready", rif.req_ready, 3'b101);
    step();
    check("c25_wr1", {reg_wr1_enable, reg_wr1, reg_wr1_data}, {1'b1, 6'd9, 16'haaaa});
    check("c25_wr2", {reg_wr2_enable, reg_wr2, reg_wr2_data}, {1'b1, 6'd12, 16'hcccc});
    rif.req_valid = 3'b010;
    #1 check("c25_ready2", rif.req_ready, 3'b010);
    step();
    check("c25_wr1b", {reg_wr1_enable, reg_wr1, reg_wr1_data}, {1'b1, 6'd9, 16'hbbbb});
    check("c25_wr2_off", reg_wr2_enable, 1'b0);

    // Carry write from requester 0 (rr_ptr=2 now).
    drive(3'b001, 6'd1, 6'd0, 6'd0, 16'h0042, 16'h0, 16'h0);
    rif.req_carry = 1; rif.req_carry_en = 1;
    #1 check("c26_ready", rif.req_ready, 3'b001);
    step();
    check("c26_carry", {carrybit_wr_enable, carrybit_wr}, 2'b11);
    drive(3'b010, 6'd0, 6'd2, 6'd0, 16'h0, 16'h0077, 16'h0);
    rif.req_carry = 0;
    step();
    check("c26_no_carry", {carrybit_wr_enable, carrybit_wr}, 2'b01);
    check("c26_lsu_wr", {reg_wr1_enable, reg_wr1, reg_wr1_data}, {1'b1, 6'd2, 16'h0077});
    rif.req_carry_en = 0;

    // Register 0 clash (rr_ptr=2): requester 2 wins, 1 waits.
    drive(3'b110, 6'd0, 6'd0, 6'd0, 16'h0, 16'h0101, 16'h0202);
    #1 check("idx0_ready", rif.req_ready, 3'b100);
    step();
    check("idx0_wr1", {reg_wr1_enable, reg_wr1, reg_wr1_data, reg_wr2_enable},
          {1'b1, 6'd0, 16'h0202, 1'b0});
    rif.req_valid = 3'b010;
    #1 check("idx0_ready2", rif.req_ready, 3'b010);
    step();
    rif.req_valid = 3'b000;

    // Reset lands mid-cycle after a grant: the pending write disappears.
    drive(3'b001, 6'd33, 6'd0, 6'd0, 16'hbeef, 16'h0, 16'h0);
    step();
    check("c27_pre", {reg_wr1_enable, reg_wr1}, {1'b1, 6'd33});
    rif.req_valid = 3'b111;
    #2 reset = 1'b1;
    #1 check("c27_async", {reg_wr1_enable, reg_wr1, reg_wr1_data}, 23'd0);
    check("c27_ready_rst", rif.req_ready, 3'b000);
    step();
    check("c27_dropped", {reg_wr1_enable, reg_wr2_enable}, 2'b00);
    rif.req_valid = 3'b000;
    reset = 1'b0;
    step();

`ifdef REGFILE_SCOREBOARD_EN
    issue_valid = 1; issue_reg = 6'd20;
    #1 check("c28_issue_ok", issue_ready, 1'b1);
    step();
    issue_valid = 0; rd_reg[0] = 6'd20;
    #1 check("c28_busy", rd_busy[0], 1'b1);
    issue_valid = 1;
    #1 check("c28_issue_stall", issue_ready, 1'b0);
    issue_valid = 0;
    drive(3'b001, 6'd20, 6'd0, 6'd0, 16'h2020, 16'h0, 16'h0);
    step();
    rif.req_valid = 3'b000;
    check("c28_busy_during_wr", rd_busy[0], 1'b1);
    step();
    check("c28_cleared", rd_busy[0], 1'b0);

    drive(3'b001, 6'd3, 6'd0, 6'd0, 16'h0333, 16'h0, 16'h0);
    step();
    rif.req_valid = 3'b000;
    issue_valid = 1; issue_reg = 6'd3;
    #1 check("c29_issue_ok", issue_ready, 1'b1);
    step();
    issue_valid = 0; rd_reg[1] = 6'd3;
    #1 check("c29_set_wins", rd_busy[1], 1'b1);
`else
    issue_valid = 1; issue_reg = 6'd20; rd_reg = {6'd1, 6'd3, 6'd20};
    #1 check("nosb_issue", issue_ready, 1'b1);
    step();
    check("nosb_rd_busy", rd_busy, 3'b000);
    issue_valid = 0;
`endif
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, meaning the number of write requesters (0=ALU, 1=LSU, 2=MDU); only 3 is supported.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  3  per-requester write request
- req_ready  out  3  per-requester grant, combinational
- req_reg  in  3x6  per-requester target register index
- req_data  in  3x16  per-requester write data
- req_carry  in  1  carry value; requester 0 only
- req_carry_en  in  1  carry write request; requester 0 only
- issue_valid  in  1  decode claims a destination register
- issue_reg  in  6  claimed register index
- issue_ready  out  1  claim accepted
- rd_reg  in  3x6  read indices being sourced
- rd_busy  out  3  per-read pending-write flag
- reg_wr1, reg_wr2  out  6 each  register-file write indices
- reg_wr1_data, reg_wr2_data  out  16 each  register-file write data
- reg_wr1_enable, reg_wr2_enable  out  1 each  register-file write enables
- carrybit_wr, carrybit_wr_enable  out  1 each  carry-bit write

Function
REQ-003 A request SHALL transfer on a rising clock edge where req_valid[i] and req_ready[i] are both high.
REQ-004 At most two requests SHALL be granted per cycle; req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-005 Candidates SHALL be scanned in round-robin order starting at rr_ptr (0..2); the first valid one SHALL take port 1 and the next valid one port 2.
REQ-006 A candidate whose req_reg equals the port-1 grant's req_reg SHALL NOT take port 2; scanning SHALL continue to the remaining requester.
REQ-007 After any grant, rr_ptr SHALL become (last granted index + 1) mod 3; with no grant it SHALL hold.
REQ-008 Write outputs SHALL be registered: one-cycle latency from the transfer edge to reg_wrN_enable high; with no grant on a port, that port's enable SHALL be low the next cycle.
REQ-009 A port with its enable low SHALL hold its last index and data values.
REQ-010 carrybit_wr_enable SHALL be high in the cycle after requester 0 transfers with req_carry_en high; carrybit_wr SHALL then equal the registered req_carry.
REQ-011 Register index 0 SHALL be treated like any other index.
REQ-012 Requests held without a grant SHALL keep their req_reg, req_data and carry fields stable until they transfer.

Reset
REQ-013 On reset, all enables, indices, data, carrybit_wr, rr_ptr and scoreboard bits SHALL clear to 0 immediately.
REQ-014 A write registered before reset SHALL be dropped and never reach the register file.
REQ-015 req_ready SHALL be 0 while reset is high.

Configuration
REQ-016 Macro REGFILE_SCOREBOARD_EN SHALL compile in a 64-bit pending-write scoreboard.
REQ-017 With the macro: issue_valid and issue_ready SHALL set bit issue_reg on the edge.
REQ-018 With the macro: reg_wrN_enable high SHALL clear bit reg_wrN on the edge.
REQ-019 With the macro: when a set and a clear hit the same bit on one edge, the set SHALL win.
REQ-020 With the macro: issue_ready SHALL equal !busy[issue_reg], and rd_busy[k] SHALL equal busy[rd_reg[k]].
REQ-021 Without the macro: issue_ready SHALL be tied to 1, rd_busy to 0, and no scoreboard flops SHALL exist.

Structure
REQ-022 Constants for the register-index width (6), data width (16), NREQ and the requester-ID encodings SHALL live in the shared processor package.
REQ-023 The scoreboard SHALL be a separate sub-module, regfile_scoreboard, instantiated only under REGFILE_SCOREBOARD_EN.

Verification
REQ-024 Directed case: after reset (rr_ptr=0), all three valid with reg 5/6/7 and data 0x1111/0x2222/0x3333 -> ready=3'b011, next cycle wr1=5/0x1111 and wr2=6/0x2222, then requester 2 is granted and rr_ptr=0.
REQ-025 Directed case: requesters 0 and 1 both target reg 9 and requester 2 targets reg 12 -> grants go to 0 and 2; requester 1 is granted next cycle and wr1=9.
REQ-026 Directed case: requester 0 with req_carry_en=1 and req_carry=1 -> carrybit_wr_enable=1 and carrybit_wr=1 exactly one cycle after transfer; no carry write when requester 1 alone is granted.
REQ-027 Directed case: reset asserted in the cycle after a grant -> reg_wr1_enable=0 with no clock edge needed, and the pending write never appears.
REQ-028 Directed case (macro on): issue reg 20, then rd_reg[0]=20 -> rd_busy[0]=1 and a second issue to reg 20 gives issue_ready=0; after the write to 20 is driven, rd_busy[0]=0 the following cycle.
REQ-029 Directed case (macro on): issue to reg 3 on the same edge as reg_wr1=3 with enable high -> busy[3] stays 1.
